// File: rtl/spr_pkg.sv
// Shared encodings for the stone-paper-scissors judge and its match controller.
// Moves, verdicts and judge states match the judge's port encodings bit for bit.
package spr_pkg;

  typedef enum logic [1:0] {
    MV_STONE    = 2'b00,
    MV_PAPER    = 2'b01,
    MV_SCISSORS = 2'b10,
    MV_INVALID  = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    VD_TIE = 2'b00,
    VD_P1  = 2'b01,
    VD_P2  = 2'b10,
    VD_BAD = 2'b11
  } verdict_e;

  typedef enum logic [2:0] {
    JS_IDLE   = 3'b000,
    JS_EVAL   = 3'b001,
    JS_RESULT = 3'b010
  } judge_state_e;

  localparam logic [2:0] SCORE_MAX = 3'd7;

  // Two LFSR bits give four codes; the invalid code is folded onto a legal move.
  function automatic logic [1:0] lfsr_to_move(input logic [7:0] v);
    logic [1:0] mv;
    if (v[1:0] == MV_INVALID) begin
      mv = v[2] ? MV_SCISSORS : MV_STONE;
    end else begin
      mv = v[1:0];
    end
    return mv;
  endfunction

  function automatic logic [2:0] score_inc(input logic [2:0] s);
    logic [2:0] r;
    if (s == SCORE_MAX) begin
      r = s;
    end else begin
      r = s + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spr_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used as Player 2's move source.
// A zero seed is replaced by 8'h01 so the register can never lock up.
module spr_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [7:0] shifted;
  logic       fb;

  // Next-state: shift left, feedback from bits 7,5,4,3.
  always_comb begin
    fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    shifted = {lfsr_q[6:0], fb};
    if (shifted == 8'h00) begin
      lfsr_d = 8'h01;
    end else begin
      lfsr_d = shifted;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/spr_match_controller.sv
// Initiator-side match controller for the stone-paper-scissors judge: captures moves,
// runs the start/evaluate/result handshake with a watchdog, and keeps the match score.
module spr_match_controller
  import spr_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] p1_move_in,
  input  logic       p1_valid,
  input  logic       mode,
  input  logic [1:0] p2_move_in,
  input  logic       new_match,
  input  logic [1:0] winner,
  input  logic [2:0] judge_state,
  output logic       start,
  output logic [1:0] p1_move,
  output logic [1:0] p2_move,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [1:0] last_result,
  output logic       ready,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       error
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 2) > 4) ? $clog2(TIMEOUT + 2) : 4;
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
  localparam logic [2:0]       WIN_SCORE = 3'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    M_IDLE      = 3'd0,
    M_WAIT_EVAL = 3'd1,
    M_RELEASE   = 3'd2,
    M_DONE      = 3'd3,
    M_ERROR     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [1:0]       p1_move_q, p1_move_d;
  logic [1:0]       p2_move_q, p2_move_d;
  logic [2:0]       p1_score_q, p1_score_d;
  logic [2:0]       p2_score_q, p2_score_d;
  logic [1:0]       last_result_q, last_result_d;
  logic             ready_q, ready_d;
  logic             match_over_q, match_over_d;
  logic [1:0]       match_winner_q, match_winner_d;
  logic             error_q, error_d;
  logic [7:0]       lfsr;

  spr_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    p1_move_d     = p1_move_q;
    p2_move_d     = p2_move_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    last_result_d = last_result_q;
    error_d       = error_q;

    case (state_q)
      M_IDLE: begin
        if (new_match) begin
          p1_score_d    = 3'd0;
          p2_score_d    = 3'd0;
          last_result_d = 2'b00;
          error_d       = 1'b0;
        end else if (p1_valid) begin
          p1_move_d = p1_move_in;
          p2_move_d = mode ? p2_move_in : lfsr_to_move(lfsr);
          state_d   = M_WAIT_EVAL;
        end else begin
          state_d = M_IDLE;
        end
      end

      M_WAIT_EVAL: begin
        if (judge_state == JS_EVAL) begin
          last_result_d = winner;
          if (winner == VD_P1) begin
            p1_score_d = score_inc(p1_score_q);
          end else if (winner == VD_P2) begin
            p2_score_d = score_inc(p2_score_q);
          end else begin
            p1_score_d = p1_score_q;
          end
          state_d = M_RELEASE;
        end else if (cnt_q >= TMO) begin
          error_d = 1'b1;
          state_d = M_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      M_RELEASE: begin
        if (judge_state == JS_IDLE) begin
          if ((p1_score_q == WIN_SCORE) || (p2_score_q == WIN_SCORE)) begin
            state_d = M_DONE;
          end else begin
            state_d = M_IDLE;
          end
        end else if (cnt_q >= TMO) begin
          error_d = 1'b1;
          state_d = M_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      M_DONE, M_ERROR: begin
        // Both terminal states leave only through a fresh match.
        if (new_match) begin
          p1_score_d    = 3'd0;
          p2_score_d    = 3'd0;
          last_result_d = 2'b00;
          error_d       = 1'b0;
          state_d       = M_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = M_IDLE;
      end
    endcase

    start_d      = (state_d == M_WAIT_EVAL);
    ready_d      = (state_d == M_IDLE);
    match_over_d = (state_d == M_DONE);
    if (state_d == M_DONE) begin
      if (p1_score_d == WIN_SCORE) begin
        match_winner_d = VD_P1;
      end else if (p2_score_d == WIN_SCORE) begin
        match_winner_d = VD_P2;
      end else begin
        match_winner_d = 2'b00;
      end
    end else begin
      match_winner_d = 2'b00;
    end
  end

  // Controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= M_IDLE;
      cnt_q          <= '0;
      start_q        <= 1'b0;
      p1_move_q      <= 2'b00;
      p2_move_q      <= 2'b00;
      p1_score_q     <= 3'd0;
      p2_score_q     <= 3'd0;
      last_result_q  <= 2'b00;
      ready_q        <= 1'b1;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'b00;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      start_q        <= start_d;
      p1_move_q      <= p1_move_d;
      p2_move_q      <= p2_move_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      last_result_q  <= last_result_d;
      ready_q        <= ready_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
      error_q        <= error_d;
    end
  end

  assign start        = start_q;
  assign p1_move      = p1_move_q;
  assign p2_move      = p2_move_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign last_result  = last_result_q;
  assign ready        = ready_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign error        = error_q;

endmodule

// File: tb/tb_spr_match_controller.sv
// Directed bench for spr_match_controller with a behavioural judge and a reference LFSR.
module tb_spr_match_controller;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clk;
  logic       reset;
  logic [1:0] p1_move_in;
  logic       p1_valid;
  logic       mode;
  logic [1:0] p2_move_in;
  logic       new_match;
  logic [1:0] winner;
  logic [2:0] judge_state;
  logic       start;
  logic [1:0] p1_move;
  logic [1:0] p2_move;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] last_result;
  logic       ready;
  logic       match_over;
  logic [1:0] match_winner;
  logic       error;

  logic       hold_idle;
  logic [7:0] lfsr_ref;
  int         n_checks;
  int         n_errors;

  spr_match_controller #(
    .ROUNDS_TO_WIN (2),
    .LFSR_SEED     (SEED),
    .TIMEOUT       (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p1_move_in   (p1_move_in),
    .p1_valid     (p1_valid),
    .mode         (mode),
    .p2_move_in   (p2_move_in),
    .new_match    (new_match),
    .winner       (winner),
    .judge_state  (judge_state),
    .start        (start),
    .p1_move      (p1_move),
    .p2_move      (p2_move),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .last_result  (last_result),
    .ready        (ready),
    .match_over   (match_over),
    .match_winner (match_winner),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] judge_verdict(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == b) return 2'b00;
    if ((a == 2'b00 && b == 2'b10) || (a == 2'b01 && b == 2'b00) || (a == 2'b10 && b == 2'b01))
      return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  function automatic logic [1:0] ref_move(input logic [7:0] v);
    logic [1:0] m;
    m = v[1:0];
    if (m == 2'b11) m = v[2] ? 2'b10 : 2'b00;
    return m;
  endfunction

  // Behavioural judge: idle -> evaluate on start, then result, then idle.
  initial begin
    logic       st;
    logic [2:0] nxt;
    judge_state = 3'b000;
    winner      = 2'b00;
    forever begin
      @(posedge clk);
      st = start;
      case (judge_state)
        3'b000:  nxt = (st && !hold_idle) ? 3'b001 : 3'b000;
        3'b001:  nxt = 3'b010;
        default: nxt = 3'b000;
      endcase
      #2;
      if (nxt == 3'b001) winner = judge_verdict(p1_move, p2_move);
      judge_state = nxt;
    end
  end

  // Reference LFSR tracking the DUT's free-running Player 2 source.
  initial begin
    lfsr_ref = SEED;
    forever begin
      @(posedge clk);
      if (!reset) lfsr_ref = SEED;
      else        lfsr_ref = ref_step(lfsr_ref);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "bench time limit");
  end

  // One round from strobe (cycle T) through T+5.
  task automatic do_round(input logic [1:0] p1, input logic [1:0] p2,
                          input logic [2:0] e1, input logic [2:0] e2,
                          input logic [1:0] eres, input logic eover,
                          input logic [1:0] ewin, input string tag);
    logic [1:0] ep2;
    ep2 = mode ? p2 : ref_move(lfsr_ref);
    p1_move_in = p1;
    p2_move_in = p2;
    p1_valid   = 1'b1;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    chk({tag, "_start_t1"}, 8'(start), 8'h01);
    chk({tag, "_ready_t1"}, 8'(ready), 8'h00);
    chk({tag, "_p1mv_t1"}, 8'(p1_move), 8'(p1));
    chk({tag, "_p2mv_t1"}, 8'(p2_move), 8'(ep2));
    if (!mode) chk({tag, "_p2_legal"}, 8'(p2_move == 2'b11), 8'h00);
    @(posedge clk); #1;
    chk({tag, "_start_t2"}, 8'(start), 8'h01);
    @(posedge clk); #1;
    chk({tag, "_start_t3"}, 8'(start), 8'h00);
    chk({tag, "_p1s_t3"}, 8'(p1_score), 8'(e1));
    chk({tag, "_p2s_t3"}, 8'(p2_score), 8'(e2));
    chk({tag, "_res_t3"}, 8'(last_result), 8'(eres));
    @(posedge clk); #1;
    chk({tag, "_p2mv_t4"}, 8'(p2_move), 8'(ep2));
    chk({tag, "_ready_t4"}, 8'(ready), 8'h00);
    @(posedge clk); #1;
    chk({tag, "_ready_t5"}, 8'(ready), 8'(!eover));
    chk({tag, "_over_t5"}, 8'(match_over), 8'(eover));
    chk({tag, "_mwin_t5"}, 8'(match_winner), 8'(ewin));
  endtask

  task automatic pulse_new_match();
    new_match = 1'b1;
    @(posedge clk); #1;
    new_match = 1'b0;
  endtask

  initial begin
    int n_start;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    p1_move_in = 2'b00;
    p1_valid   = 1'b0;
    mode       = 1'b1;
    p2_move_in = 2'b00;
    new_match  = 1'b0;
    hold_idle  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", 8'(start), 8'h00);
    chk("rst_ready", 8'(ready), 8'h01);
    chk("rst_over", 8'(match_over), 8'h00);
    chk("rst_error", 8'(error), 8'h00);
    chk("rst_p1s", 8'(p1_score), 8'h00);
    chk("rst_p2s", 8'(p2_score), 8'h00);
    chk("rst_res", 8'(last_result), 8'h00);
    chk("rst_mwin", 8'(match_winner), 8'h00);
    chk("rst_moves", 8'({p1_move, p2_move}), 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;

    // Stone beats scissors.
    do_round(2'b00, 2'b10, 3'd1, 3'd0, 2'b01, 1'b0, 2'b00, "r1");

    // new_match and p1_valid together: new_match wins.
    new_match  = 1'b1;
    p1_valid   = 1'b1;
    p1_move_in = 2'b01;
    @(posedge clk); #1;
    new_match = 1'b0;
    p1_valid  = 1'b0;
    chk("nm_vs_valid_start", 8'(start), 8'h00);
    chk("nm_vs_valid_ready", 8'(ready), 8'h01);
    chk("nm_vs_valid_p1s", 8'(p1_score), 8'h00);

    // P1 takes the match 2-0.
    do_round(2'b01, 2'b00, 3'd1, 3'd0, 2'b01, 1'b0, 2'b00, "m1r1");
    do_round(2'b10, 2'b01, 3'd2, 3'd0, 2'b01, 1'b1, 2'b01, "m1r2");

    p1_valid = 1'b1;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    chk("done_ign_start", 8'(start), 8'h00);
    chk("done_ign_over", 8'(match_over), 8'h01);
    chk("done_ign_p1s", 8'(p1_score), 8'h02);
    @(posedge clk); #1;
    chk("done_ign_start2", 8'(start), 8'h00);

    pulse_new_match();
    chk("nm_ready", 8'(ready), 8'h01);
    chk("nm_over", 8'(match_over), 8'h00);
    chk("nm_p1s", 8'(p1_score), 8'h00);
    chk("nm_res", 8'(last_result), 8'h00);
    chk("nm_mwin", 8'(match_winner), 8'h00);

    // Tie then void: no score movement.
    do_round(2'b01, 2'b01, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, "tie");
    do_round(2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 1'b0, 2'b00, "void");

    // P2 takes a match 2-0.
    do_round(2'b00, 2'b01, 3'd0, 3'd1, 2'b10, 1'b0, 2'b00, "m2r1");
    do_round(2'b10, 2'b00, 3'd0, 3'd2, 2'b10, 1'b1, 2'b10, "m2r2");
    pulse_new_match();
    chk("nm2_p2s", 8'(p2_score), 8'h00);

    // Watchdog: judge never leaves idle.
    hold_idle  = 1'b1;
    p1_move_in = 2'b00;
    p2_move_in = 2'b01;
    p1_valid   = 1'b1;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    n_start  = 0;
    while (start && n_start < 40) begin
      n_start = n_start + 1;
      @(posedge clk); #1;
    end
    chk("tmo_start_cycles", 8'(n_start), 8'd16);
    chk("tmo_error", 8'(error), 8'h01);
    chk("tmo_start", 8'(start), 8'h00);
    chk("tmo_ready", 8'(ready), 8'h00);
    chk("tmo_over", 8'(match_over), 8'h00);
    hold_idle = 1'b0;
    p1_valid  = 1'b1;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    chk("err_ign_start", 8'(start), 8'h00);
    chk("err_sticky", 8'(error), 8'h01);
    pulse_new_match();
    chk("err_clr_error", 8'(error), 8'h00);
    chk("err_clr_ready", 8'(ready), 8'h01);

    // Reset asserted at T+2 of a round.
    do_round(2'b00, 2'b10, 3'd1, 3'd0, 2'b01, 1'b0, 2'b00, "pre_rst");
    p1_move_in = 2'b01;
    p2_move_in = 2'b00;
    p1_valid   = 1'b1;
    @(posedge clk); #1;
    p1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_start", 8'(start), 8'h00);
    chk("midrst_p1s", 8'(p1_score), 8'h00);
    chk("midrst_ready", 8'(ready), 8'h01);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // LFSR-driven Player 2 over 20 void rounds.
    mode = 1'b0;
    for (int r = 0; r < 20; r++) begin
      do_round(2'b11, 2'b00, 3'd0, 3'd0, 2'b11, 1'b0, 2'b00, $sformatf("lfsr%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
